// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths and types for the CNN core datapath.
package cnn_pkg;
    localparam int DATA_W      = 32;
    localparam int POOL_WINDOW = 4;
    localparam int POOL_LOG2   = 2;
    typedef logic signed [DATA_W-1:0]           data_t;
    typedef logic signed [DATA_W+POOL_LOG2-1:0] pool_acc_t;
endpackage

// File: rtl/avg_pool_unit.sv
// avg_pool_unit: streaming WINDOW-sample signed average with registered output.
// Define AVG_POOL_ROUND_EN to round half toward +inf instead of flooring.
module avg_pool_unit
    import cnn_pkg::*;
#(
    parameter int DATA_W      = cnn_pkg::DATA_W,
    parameter int WINDOW      = cnn_pkg::POOL_WINDOW,
    parameter int LOG2_WINDOW = cnn_pkg::POOL_LOG2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] layer2,
    input  logic                     enable,
    output logic signed [DATA_W-1:0] avg,
    output logic                     avg_valid
);
    localparam int ACC_W = DATA_W + LOG2_WINDOW;
    logic signed [ACC_W-1:0]       sum;
    logic signed [ACC_W-1:0]       total;
    logic        [LOG2_WINDOW-1:0] cnt;
    logic                          last;
    logic signed [DATA_W-1:0]      avg_next;
`ifdef AVG_POOL_ROUND_EN
    // One extra bit keeps the rounding addend from wrapping the accumulator.
    logic signed [ACC_W:0] rtotal;
    assign rtotal = $signed({total[ACC_W-1], total}) + $signed((ACC_W+1)'(WINDOW / 2));
`else
    logic signed [ACC_W-1:0] rtotal;
    assign rtotal = total;
`endif
    assign total    = sum + $signed({{LOG2_WINDOW{layer2[DATA_W-1]}}, layer2});
    assign last     = cnt == LOG2_WINDOW'(WINDOW - 1);
    assign avg_next = DATA_W'(rtotal >>> LOG2_WINDOW);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum       <= '0;
            cnt       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= enable && last;
            if (enable) begin
                sum <= last ? '0 : total;
                cnt <= last ? '0 : cnt + 1'b1;
                if (last)
                    avg <= avg_next;
            end
        end
    end
endmodule

// File: tb/tb_avg_pool_unit.sv
// tb_avg_pool_unit: scoreboard bench for avg_pool_unit, default or rounding build.
module tb_avg_pool_unit;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [31:0] layer2 = '0;
    logic               enable = 1'b0;
    logic signed [31:0] avg;
    logic               avg_valid;
    int                 total = 0;
    int                 bad = 0;
    int                 cyc = 0;
    int                 prev_v = -1;
    int                 last_v = -1;
    logic signed [31:0] q[$];
    logic signed [31:0] exp_v;

    avg_pool_unit dut (
        .clk(clk), .rst(rst), .layer2(layer2), .enable(enable),
        .avg(avg), .avg_valid(avg_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (avg_valid === 1'b1) begin
            prev_v = last_v;
            last_v = cyc;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: avg_valid with avg=%0d but none expected", avg);
            end else begin
                exp_v = q.pop_front();
                if (avg !== exp_v) begin
                    bad++;
                    $display("FAIL sb_avg: got %0d expected %0d", avg, exp_v);
                end
            end
        end
    end

    task automatic send(input logic signed [31:0] v);
        enable = 1'b1;
        layer2 = v;
        @(posedge clk);
        #1;
        enable = 1'b0;
        layer2 = 'x;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        layer2 = 'x;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d results still pending, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (avg !== 32'sd0 || avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset: avg=%0d avg_valid=%b, required 0/0", avg, avg_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        q.push_back(32'sd25);
        send(10); send(20); send(30); send(40);
        @(negedge clk);
        total++;
        if (avg_valid !== 1'b1 || avg !== 32'sd25) begin
            bad++;
            $display("FAIL basic_pulse: avg=%0d avg_valid=%b, required 25/1", avg, avg_valid);
        end
        repeat (5) @(negedge clk);
        total++;
        if (avg !== 32'sd25 || avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold: avg=%0d avg_valid=%b, required 25/0", avg, avg_valid);
        end
        drain("basic");
    endtask

    task automatic test_negative;
`ifdef AVG_POOL_ROUND_EN
        q.push_back(-32'sd2);
`else
        q.push_back(-32'sd3);
`endif
        send(-1); send(-2); send(-3); send(-4);
        drain("negative");
    endtask

    task automatic test_overflow;
        q.push_back(32'sh7FFFFFFF);
        repeat (4) send(32'sh7FFFFFFF);
        drain("ovf_max");
        q.push_back(32'sh80000000);
        repeat (4) send(32'sh80000000);
        drain("ovf_min");
    endtask

    task automatic test_gaps;
        q.push_back(32'sd10);
        send(4); idle(3);
        send(8); idle(1);
        send(12);
        @(negedge clk);
        total++;
        if (avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL gaps_early: avg_valid=%b after 3 samples, required 0", avg_valid);
        end
        send(16);
        drain("gaps");
    endtask

    task automatic test_back_to_back;
        logic signed [31:0] s[8] = '{1, 1, 1, 1, 100, 200, 300, 400};
        q.push_back(32'sd1);
        q.push_back(32'sd250);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            layer2 = s[i];
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        layer2 = 'x;
        drain("b2b");
        total++;
        if (last_v - prev_v !== 4) begin
            bad++;
            $display("FAIL b2b_spacing: pulses %0d cycles apart, required 4", last_v - prev_v);
        end
    endtask

    task automatic test_mid_reset;
        send(50); send(50);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (avg !== 32'sd0 || avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: avg=%0d avg_valid=%b, required 0/0", avg, avg_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(32'sd5);
        send(2); send(4); send(6); send(8);
        drain("mid_reset");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_negative;
        test_overflow;
        test_gaps;
        test_back_to_back;
        test_mid_reset;
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/avg_pool_unit.md
Name: avg_pool_unit

Overview:
- Streaming 2x2 average-pooling arithmetic unit used by the CNN core pooling layer.
- Accepts one signed sample per enabled clock and accumulates a window of WINDOW samples.
- When the window completes, outputs the window average and holds it until the next window completes.
- The pooling-layer controller feeds the four pixels of a 2x2 block, then reads avg after a fixed wait.

Parameters:
- DATA_W, 32: width of the input sample and the output average (signed two's complement).
- WINDOW, 4: samples per average; must be a power of two, at least 2.
- LOG2_WINDOW, 2: log2(WINDOW); used for the sample counter width and the shift amount.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (keeps the codebase port name rst; low = reset).
- layer2  input  DATA_W  signed input sample from the preceding layer.
- enable  input  1  high = layer2 is a valid sample and is accepted this cycle.
- avg  output  DATA_W  signed average of the most recently completed window; registered.
- avg_valid  output  1  one-cycle pulse concurrent with each new avg value.

Behaviour:
- Internal state:
  - sum: signed accumulator, DATA_W+LOG2_WINDOW bits.
  - cnt: sample counter, LOG2_WINDOW bits.
- Reset (rst=0, asynchronous assert; deassert synchronised by the system):
  - sum=0, cnt=0, avg=0, avg_valid=0.
  - Reset mid-window discards the partial window entirely.
- States are implicit in cnt:
  - ACCUM, while cnt < WINDOW-1.
  - COMPLETE, the cycle that takes the WINDOW-th sample.
- enable=0:
  - sum and cnt hold.
  - avg holds; avg_valid=0.
  - Gaps between samples inside a window are legal.
- enable=1 and cnt != WINDOW-1:
  - sum <= sum + sext(layer2); cnt <= cnt+1; avg_valid <= 0.
- enable=1 and cnt == WINDOW-1:
  - total = sum + sext(layer2), computed at full DATA_W+LOG2_WINDOW width so no intermediate overflow.
  - avg <= total >>> LOG2_WINDOW (arithmetic shift, i.e. floor toward minus infinity), truncated to DATA_W bits.
  - The result always fits in DATA_W bits, so no saturation is needed.
  - avg_valid <= 1; sum <= 0; cnt <= 0.
- Latency: avg is updated at the same clock edge that samples the last input. It is readable one cycle later and stable for all subsequent cycles until the next window completes.
  - A controller waiting 1 or more cycles after the last enable therefore reads the correct value.
- Back-to-back windows: continuous enable produces a new avg every WINDOW cycles, with no bubble required.
- The first sample of the next window may arrive in the cycle immediately after COMPLETE.
- The unit has no synchronous clear. Callers align windows by feeding exactly WINDOW samples, or by asserting rst.
- Input X/Z with enable=0 must not corrupt state.

Optional Feature:
- Macro: AVG_POOL_ROUND_EN.
- Defined: avg = (total + WINDOW/2) >>> LOG2_WINDOW, i.e. round half toward plus infinity. The addend must not overflow the accumulator width; widen by 1 bit if required.
- Undefined: plain floor via arithmetic shift, as specified above.
- All other timing is identical in both builds.

Decomposition:
- Package cnn_pkg holds:
  - DATA_W (32), POOL_WINDOW (4) and POOL_LOG2 (2) as localparams.
  - typedef data_t = logic signed [DATA_W-1:0].
  - typedef pool_acc_t = logic signed [DATA_W+POOL_LOG2-1:0].
- No sub-module is needed; the accumulator and counter are a single flat block.

Test Plan:
- Basic average: reset, then feed 10, 20, 30, 40 on consecutive enabled cycles -> avg=25 and avg_valid pulses once, one cycle after the 4th sample. avg still reads 25 five cycles later.
- Negative floor: feed -1, -2, -3, -4 -> avg=-3 (floor of -2.5). With AVG_POOL_ROUND_EN defined -> avg=-2.
- Overflow guard:
  - Four samples of 0x7FFFFFFF -> avg=0x7FFFFFFF.
  - Four samples of 0x80000000 -> avg=0x80000000.
- Enable gaps: feed 4, gap 3 cycles, 8, gap 1 cycle, 12, 16 -> avg=10. avg_valid asserts only after the 4th accepted sample.
- Back-to-back windows: continuous enable with 1, 1, 1, 1, 100, 200, 300, 400 -> avg=1, then avg=250 exactly 4 cycles later, with no missing samples.
- Reset mid-window: feed 50, 50, pull rst low asynchronously between edges, release, then feed 2, 4, 6, 8 -> avg=0 during reset, then avg=5.
